// File: rtl/usb_packet_pkg.sv
// Shared types and limits for the USB receive path: FSM state encoding,
// SYNC hunt threshold, maximum packet length and the PID integrity check.
`default_nettype none

package usb_packet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DRAIN   = 2'd2
  } rx_state_e;

  localparam logic [2:0]  SYNC_MIN_ZEROS   = 3'd5;
  localparam logic [10:0] MAX_PACKET_BYTES = 11'd1027;

  // A PID carries its own check field: the high nibble is the complement of the low nibble.
  function automatic logic pid_is_valid(input logic [7:0] pid);
    return pid[3:0] == ~pid[7:4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_sync_detect.sv
// SYNC hunt: counts consecutive valid zero bits (saturating at 7) and flags
// the terminating one bit once enough zeros have been seen.
`default_nettype none

module usb_sync_detect
  import usb_packet_pkg::*;
(
  input  logic clk12,
  input  logic RST,
  input  logic clear,
  input  logic bitValid,
  input  logic bitIn,
  output logic syncFound
);

  logic [2:0] zeros_q;
  logic [2:0] zeros_d;

  always_comb begin
    zeros_d = zeros_q;
    if (clear) begin
      zeros_d = '0;
    end else if (bitValid) begin
      if (bitIn) begin
        zeros_d = '0;
      end else if (zeros_q != 3'd7) begin
        zeros_d = zeros_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk12 or negedge RST) begin
    if (!RST) begin
      zeros_q <= '0;
    end else begin
      zeros_q <= zeros_d;
    end
  end

  assign syncFound = !clear && bitValid && bitIn && (zeros_q >= SYNC_MIN_ZEROS);

endmodule

`default_nettype wire

// File: rtl/usb_rx_deserializer.sv
// USB receive deserializer: SYNC hunt, LSB-first byte assembly, PID check,
// length limit and EOP/abort handling with done/error pulses.
`default_nettype none

module usb_rx_deserializer
  import usb_packet_pkg::*;
(
  input  logic        clk12,
  input  logic        RST,
  input  logic        rxEnable,
  input  logic        bitValid,
  input  logic        bitIn,
  input  logic        stuffError,
  input  logic        eopDetected,
  output logic [7:0]  byteOut,
  output logic        byteValid,
  output logic        byteIsPid,
  output logic [10:0] byteCount,
  output logic        packetActive,
  output logic        packetDone,
  output logic        packetError
);

  rx_state_e   state_q,     state_d;
  logic [2:0]  bitcnt_q,    bitcnt_d;
  logic [7:0]  shift_q,     shift_d;
  logic        pend_q,      pend_d;
  logic [7:0]  byteOut_q,   byteOut_d;
  logic        byteValid_q, byteValid_d;
  logic        byteIsPid_q, byteIsPid_d;
  logic [10:0] byteCount_q, byteCount_d;
  logic        done_q,      done_d;
  logic        err_q,       err_d;

  logic        sync_clear;
  logic        sync_found;
  logic [10:0] total_bytes;
  logic        pid_bad;

  assign sync_clear = !rxEnable || (state_q != ST_IDLE);

  usb_sync_detect u_sync_detect (
    .clk12     (clk12),
    .RST       (RST),
    .clear     (sync_clear),
    .bitValid  (bitValid),
    .bitIn     (bitIn),
    .syncFound (sync_found)
  );

  // A completed byte waits one cycle in the shift register (pend_q) before it is
  // published, so an EOP right after the last bit sees it and can report done.
  assign total_bytes = byteCount_q + {10'd0, pend_q};
  assign pid_bad     = pend_q && (byteCount_q == 11'd0) && !pid_is_valid(shift_q);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    pend_d      = 1'b0;
    byteOut_d   = byteOut_q;
    byteValid_d = 1'b0;
    byteIsPid_d = 1'b0;
    byteCount_d = byteCount_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (!rxEnable) begin
      state_d     = ST_IDLE;
      bitcnt_d    = '0;
      shift_d     = '0;
      byteCount_d = '0;
    end else begin
      if (pend_q) begin
        byteOut_d   = shift_q;
        byteValid_d = 1'b1;
        byteIsPid_d = (byteCount_q == 11'd0);
        byteCount_d = byteCount_q + 11'd1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (sync_found) begin
            state_d     = ST_RECEIVE;
            bitcnt_d    = '0;
            shift_d     = '0;
            byteCount_d = '0;
          end
        end
        ST_RECEIVE: begin
          if (eopDetected) begin
            state_d = ST_IDLE;
            if (!pid_bad && (bitcnt_q == 3'd0) && (total_bytes != 11'd0)) begin
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (stuffError || pid_bad) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else if (bitValid) begin
            if ((bitcnt_q == 3'd0) && (total_bytes == MAX_PACKET_BYTES)) begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              shift_d  = {bitIn, shift_q[7:1]};
              bitcnt_d = bitcnt_q + 3'd1;
              pend_d   = (bitcnt_q == 3'd7);
            end
          end
        end
        ST_DRAIN: begin
          if (eopDetected) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk12 or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      pend_q      <= 1'b0;
      byteOut_q   <= '0;
      byteValid_q <= 1'b0;
      byteIsPid_q <= 1'b0;
      byteCount_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      byteOut_q   <= byteOut_d;
      byteValid_q <= byteValid_d;
      byteIsPid_q <= byteIsPid_d;
      byteCount_q <= byteCount_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign byteOut      = byteOut_q;
  assign byteValid    = byteValid_q;
  assign byteIsPid    = byteIsPid_q;
  assign byteCount    = byteCount_q;
  assign packetActive = (state_q == ST_RECEIVE);
  assign packetDone   = done_q;
  assign packetError  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_deserializer.sv
// Directed self-checking bench for usb_rx_deserializer.
`default_nettype none

module tb_usb_rx_deserializer;

  logic        clk12 = 1'b0;
  logic        RST = 1'b0;
  logic        rxEnable = 1'b1;
  logic        bitValid = 1'b0;
  logic        bitIn = 1'b0;
  logic        stuffError = 1'b0;
  logic        eopDetected = 1'b0;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        byteIsPid;
  logic [10:0] byteCount;
  logic        packetActive;
  logic        packetDone;
  logic        packetError;

  int total = 0;
  int bad = 0;

  logic [7:0]  bytes_q[$];
  int          n_bytes, n_pid, n_done, n_err, n_both, n_done_with_byte;
  logic [10:0] last_count;

  usb_rx_deserializer dut (
    .clk12        (clk12),
    .RST          (RST),
    .rxEnable     (rxEnable),
    .bitValid     (bitValid),
    .bitIn        (bitIn),
    .stuffError   (stuffError),
    .eopDetected  (eopDetected),
    .byteOut      (byteOut),
    .byteValid    (byteValid),
    .byteIsPid    (byteIsPid),
    .byteCount    (byteCount),
    .packetActive (packetActive),
    .packetDone   (packetDone),
    .packetError  (packetError)
  );

  always #5 clk12 = ~clk12;

  always @(negedge clk12) begin
    if (byteValid) begin
      bytes_q.push_back(byteOut);
      n_bytes++;
      if (byteIsPid) n_pid++;
      last_count = byteCount;
      if (packetDone) n_done_with_byte++;
    end
    if (packetDone) n_done++;
    if (packetError) n_err++;
    if (packetDone && packetError) n_both++;
  end

  task automatic clear_log();
    bytes_q.delete();
    n_bytes = 0; n_pid = 0; n_done = 0; n_err = 0; n_both = 0;
    n_done_with_byte = 0; last_count = '0;
  endtask

  task automatic drive(input logic v, input logic b, input logic e, input logic s);
    bitValid = v; bitIn = b; eopDetected = e; stuffError = s;
    @(posedge clk12); #1;
    bitValid = 1'b0; bitIn = 1'b0; eopDetected = 1'b0; stuffError = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic send_sync();
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap_at);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) drive(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(d[i]);
    end
  endtask

  task automatic send_eop();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge clk12);
    total++;
    if ({byteOut, byteValid, byteIsPid, byteCount, packetActive, packetDone, packetError} !== 24'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {byteOut, byteValid, byteIsPid, byteCount, packetActive, packetDone, packetError});
    end
    @(posedge clk12); #1;
    RST = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_log();
    send_sync();
    total++;
    if (packetActive !== 1'b1) begin bad++; $display("FAIL basic_active got=%b want=1", packetActive); end
    send_byte(8'h2D, 8);
    send_eop();
    idle(3);
    total++;
    if (n_bytes != 1) begin bad++; $display("FAIL basic_nbytes got=%0d want=1", n_bytes); end
    total++;
    if (bytes_q.size() == 0 || bytes_q[0] !== 8'h2D) begin
      bad++; $display("FAIL basic_byte got=%h want=2d", (bytes_q.size() != 0) ? bytes_q[0] : 8'hxx);
    end
    total++;
    if (n_pid != 1 || last_count !== 11'd1) begin
      bad++; $display("FAIL basic_pid_count got pid=%0d cnt=%0d want pid=1 cnt=1", n_pid, last_count);
    end
    total++;
    if (n_done != 1 || n_err != 0) begin
      bad++; $display("FAIL basic_pulses got done=%0d err=%0d want done=1 err=0", n_done, n_err);
    end
    total++;
    if (n_done_with_byte != 1) begin
      bad++; $display("FAIL basic_done_coincident got=%0d want=1", n_done_with_byte);
    end
    total++;
    if (packetActive !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", packetActive); end
  endtask

  task automatic test_short_sync();
    clear_log();
    repeat (4) send_bit(1'b0);
    send_bit(1'b1);
    send_byte(8'h2D, 8);
    send_eop();
    idle(3);
    total++;
    if (n_bytes != 0 || n_done != 0 || n_err != 0 || packetActive !== 1'b0) begin
      bad++; $display("FAIL short_sync got bytes=%0d done=%0d err=%0d act=%b want 0 0 0 0",
                      n_bytes, n_done, n_err, packetActive);
    end
  endtask

  task automatic test_gap();
    clear_log();
    send_sync();
    send_byte(8'hC3, 8);
    send_byte(8'h55, 4);
    send_byte(8'hAA, 8);
    send_eop();
    idle(3);
    total++;
    if (bytes_q.size() != 3) begin
      bad++; $display("FAIL gap_nbytes got=%0d want=3", bytes_q.size());
    end else begin
      total++;
      if (bytes_q[0] !== 8'hC3 || bytes_q[1] !== 8'h55 || bytes_q[2] !== 8'hAA) begin
        bad++; $display("FAIL gap_bytes got=%h %h %h want=c3 55 aa", bytes_q[0], bytes_q[1], bytes_q[2]);
      end
    end
    total++;
    if (byteCount !== 11'd3 || n_pid != 1) begin
      bad++; $display("FAIL gap_count got cnt=%0d pid=%0d want cnt=3 pid=1", byteCount, n_pid);
    end
    total++;
    if (n_done != 1 || n_err != 0) begin
      bad++; $display("FAIL gap_pulses got done=%0d err=%0d want 1 0", n_done, n_err);
    end
  endtask

  task automatic test_partial_eop();
    clear_log();
    send_sync();
    send_byte(8'hC3, 8);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_eop();
    idle(3);
    total++;
    if (n_bytes != 1 || n_err != 1 || n_done != 0) begin
      bad++; $display("FAIL partial_eop got bytes=%0d err=%0d done=%0d want 1 1 0", n_bytes, n_err, n_done);
    end
    total++;
    if (packetActive !== 1'b0) begin bad++; $display("FAIL partial_eop_idle got=%b want=0", packetActive); end
  endtask

  task automatic test_pid();
    // 0xA5: high nibble A complements low nibble 5, so the PID is accepted.
    clear_log();
    send_sync();
    send_byte(8'hA5, 8);
    idle(2);
    total++;
    if (n_bytes != 1 || n_err != 0 || packetActive !== 1'b1) begin
      bad++; $display("FAIL pid_a5 got bytes=%0d err=%0d act=%b want 1 0 1", n_bytes, n_err, packetActive);
    end
    send_eop();
    idle(2);
    total++;
    if (n_done != 1) begin bad++; $display("FAIL pid_a5_done got=%0d want=1", n_done); end
    // 0x2A: high nibble 2 would need low nibble D, so the PID is rejected.
    clear_log();
    send_sync();
    send_byte(8'h2A, 8);
    idle(2);
    total++;
    if (n_bytes != 1 || n_pid != 1 || n_err != 1 || packetActive !== 1'b0) begin
      bad++; $display("FAIL pid_bad got bytes=%0d pid=%0d err=%0d act=%b want 1 1 1 0",
                      n_bytes, n_pid, n_err, packetActive);
    end
    send_byte(8'hFF, 8);
    send_byte(8'h00, 8);
    send_eop();
    idle(2);
    total++;
    if (n_bytes != 1 || n_err != 1 || n_done != 0) begin
      bad++; $display("FAIL pid_drain got bytes=%0d err=%0d done=%0d want 1 1 0", n_bytes, n_err, n_done);
    end
  endtask

  task automatic test_stuff();
    clear_log();
    send_sync();
    send_byte(8'hC3, 8);
    send_bit(1'b1); send_bit(1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    total++;
    if (n_bytes != 1 || n_err != 1 || n_done != 0 || packetActive !== 1'b0) begin
      bad++; $display("FAIL stuff got bytes=%0d err=%0d done=%0d act=%b want 1 1 0 0",
                      n_bytes, n_err, n_done, packetActive);
    end
    send_byte(8'h3C, 8);
    send_eop();
    idle(2);
    total++;
    if (n_bytes != 1 || n_err != 1 || n_done != 0) begin
      bad++; $display("FAIL stuff_drain got bytes=%0d err=%0d done=%0d want 1 1 0", n_bytes, n_err, n_done);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send_sync();
    send_byte(8'hC3, 8);
    repeat (4) send_bit(1'b1);
    total++;
    if (packetActive !== 1'b1 || byteCount !== 11'd1) begin
      bad++; $display("FAIL rstmid_pre got act=%b cnt=%0d want 1 1", packetActive, byteCount);
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if ({byteOut, byteValid, byteIsPid, byteCount, packetActive, packetDone, packetError} !== 24'd0) begin
      bad++; $display("FAIL rstmid_async got=%h want=0",
                      {byteOut, byteValid, byteIsPid, byteCount, packetActive, packetDone, packetError});
    end
    @(posedge clk12); #1;
    RST = 1'b1;
    clear_log();
    idle(3);
    total++;
    if (n_done != 0 || n_err != 0 || packetActive !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got done=%0d err=%0d act=%b want 0 0 0", n_done, n_err, packetActive);
    end
  endtask

  task automatic test_rx_disable();
    clear_log();
    send_sync();
    send_byte(8'hC3, 8);
    repeat (3) send_bit(1'b0);
    rxEnable = 1'b0;
    idle(1);
    rxEnable = 1'b1;
    idle(2);
    total++;
    if (n_bytes != 1 || n_done != 0 || n_err != 0 || packetActive !== 1'b0 || byteCount !== 11'd0) begin
      bad++; $display("FAIL rx_disable got bytes=%0d done=%0d err=%0d act=%b cnt=%0d want 1 0 0 0 0",
                      n_bytes, n_done, n_err, packetActive, byteCount);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_sync();
    send_byte(8'h4B, 8);
    send_eop();
    send_sync();
    send_byte(8'hE1, 8);
    send_byte(8'h12, 8);
    send_eop();
    idle(3);
    total++;
    if (bytes_q.size() != 3 || n_pid != 2 || n_done != 2 || n_err != 0) begin
      bad++; $display("FAIL back_to_back got bytes=%0d pid=%0d done=%0d err=%0d want 3 2 2 0",
                      bytes_q.size(), n_pid, n_done, n_err);
    end else begin
      total++;
      if (bytes_q[0] !== 8'h4B || bytes_q[1] !== 8'hE1 || bytes_q[2] !== 8'h12 || byteCount !== 11'd2) begin
        bad++; $display("FAIL back_to_back_data got=%h %h %h cnt=%0d want=4b e1 12 cnt=2",
                        bytes_q[0], bytes_q[1], bytes_q[2], byteCount);
      end
    end
  endtask

  task automatic test_overflow();
    clear_log();
    send_sync();
    send_byte(8'hC3, 8);
    repeat (1026) send_byte(8'h00, 8);
    total++;
    if (n_err != 0 || packetActive !== 1'b1) begin
      bad++; $display("FAIL overflow_early got err=%0d act=%b want 0 1", n_err, packetActive);
    end
    send_bit(1'b0);
    idle(2);
    total++;
    if (n_bytes != 1027 || n_err != 1 || packetActive !== 1'b0 || byteCount !== 11'd1027) begin
      bad++; $display("FAIL overflow got bytes=%0d err=%0d act=%b cnt=%0d want 1027 1 0 1027",
                      n_bytes, n_err, packetActive, byteCount);
    end
    send_eop();
    idle(2);
    total++;
    if (n_done != 0 || n_err != 1) begin
      bad++; $display("FAIL overflow_eop got done=%0d err=%0d want 0 1", n_done, n_err);
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_short_sync();
    test_gap();
    test_partial_eop();
    test_pid();
    test_stuff();
    test_reset_mid();
    test_rx_disable();
    test_back_to_back();
    test_overflow();
    total++;
    if (n_both != 0) begin bad++; $display("FAIL done_and_error got=%0d want=0", n_both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
